// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // A single requester still needs one owner bit.
  function automatic int own_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter, plus a state debug tap.
interface dff_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  import dff_arb_pkg::*;

  localparam int OWN_W = own_w(NUM_REQ);

  // Handshake: requester i raises req[i] with its wdata slice and holds both
  // stable until gnt[i] pulses for one cycle; the write commits at the end of
  // that cycle and req[i] is dropped afterwards.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         q;
  logic                      q_valid;
  logic [OWN_W-1:0]          owner;
  logic                      busy;
  state_t                    dbg_state;

  modport master (
    output req, wdata,
    input  gnt, q, q_valid, owner, busy, dbg_state
  );

  modport slave (
    input  req, wdata,
    output gnt, q, q_valid, owner, busy, dbg_state
  );

endinterface

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Rotating-priority finder: first set req bit at or above ptr, else lowest set bit.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = own_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic               any,
  output logic [OWN_W-1:0]   idx
);

  logic             hi_any;
  logic [OWN_W-1:0] hi_idx;
  logic [OWN_W-1:0] lo_idx;

  // Descending scan so the last hit is the lowest index in each half.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = OWN_W'(j);
        if (OWN_W'(j) >= ptr) begin
          hi_any = 1'b1;
          hi_idx = OWN_W'(j);
        end
      end
    end
    any = |req;
    idx = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin write arbiter owning one shared DATA_W-bit register, with a
// post-commit hold window so downstream logic can sample q.
module dff_reg_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dff_reg_arbiter_if.slave bus
);
  import dff_arb_pkg::*;

  localparam int OWN_W = own_w(NUM_REQ);

  state_t             state;
  state_t             state_n;
  logic [OWN_W-1:0]   ptr;
  logic [OWN_W-1:0]   win;
  logic [OWN_W-1:0]   owner_r;
  logic [OWN_W-1:0]   pick_idx;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] gnt_r;
  logic [DATA_W-1:0]  q_r;
  logic [DATA_W-1:0]  sel_data;
  logic               q_valid_r;

  rr_pick #(.NUM_REQ(NUM_REQ), .OWN_W(OWN_W)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == OWN_W'(i)) sel_data = bus.wdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_any) state_n = GRANT;
      GRANT:   state_n = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      HOLD:    if (cnt <= CNT_W'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Commit uses wdata as seen at the close of GRANT, even if req has dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win   <= pick_idx;
            gnt_r <= NUM_REQ'(1) << pick_idx;
          end
        end
        GRANT: begin
          gnt_r     <= '0;
          q_r       <= sel_data;
          owner_r   <= win;
          q_valid_r <= 1'b1;
          ptr       <= (win == OWN_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          cnt       <= CNT_W'(HOLD_CYCLES);
        end
        HOLD:    cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.q         = q_r;
  assign bus.q_valid   = q_valid_r;
  assign bus.owner     = owner_r;
  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

endmodule
